// File: rtl/serial_deser8_pkg.sv
// serial_deser8_pkg
//   Shared types and constants for the serial_deser8 deserializer slice.
//   FRAME_BITS : data bits per frame
//   SLOT_W     : width of the slot counter / demux select
//   state_t    : COLLECT (data slots 0..7), PARITY (9th bit, parity builds only)
//   even_parity_err() : 1 when {data, parity} does not have even parity
package serial_deser8_pkg;

  localparam int FRAME_BITS = 8;
  localparam int SLOT_W     = 3;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } state_t;

  // Even parity check over a data byte plus its received parity bit.
  function automatic logic even_parity_err(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/serial_deser8_dmux.sv
// dmux1to8
//   1-to-8 demultiplexer: routes the single input onto output y[sel];
//   every other output is 0.
//   in  : data input
//   sel : output select (0..7)
//   y   : one-hot-gated outputs
module dmux1to8
  import serial_deser8_pkg::*;
(
  input  logic              in,
  input  logic [SLOT_W-1:0] sel,
  output logic [7:0]        y
);

  // Steer the input onto the selected output line.
  always_comb begin
    y = 8'h00;
    case (sel)
      3'd0:    y[0] = in;
      3'd1:    y[1] = in;
      3'd2:    y[2] = in;
      3'd3:    y[3] = in;
      3'd4:    y[4] = in;
      3'd5:    y[5] = in;
      3'd6:    y[6] = in;
      3'd7:    y[7] = in;
      default: y = 8'h00;
    endcase
  end

endmodule

// File: rtl/serial_deser8.sv
// serial_deser8
//   Serial-to-parallel deserializer: a slot counter drives a 1-to-8 demux that
//   steers each accepted serial bit into an accumulate register; a completed
//   frame is copied into a separate output register presented on valid/ready.
//   Optional feature macro: SERIAL_DESER8_PARITY_EN adds a 9th even-parity bit
//   per frame and reports out_parity_err alongside out_data.
//   Parameters:
//     MSB_FIRST      : 0 -> first bit lands in out_data[0]; 1 -> in out_data[7]
//     TIMEOUT_CYCLES : idle cycles mid-frame before the partial frame is
//                      dropped; 0 disables the timeout
//   Ports:
//     clk, rst_n      : clock, async active-low reset
//     in_bit/in_valid : serial input, in_ready accepts it
//     out_data/out_valid/out_ready : byte output handshake
//     frame_abort     : one-cycle pulse when a partial frame times out
//     out_parity_err  : parity mismatch for current out_data (0 without macro)
module serial_deser8
  import serial_deser8_pkg::*;
#(
  parameter int MSB_FIRST      = 0,
  parameter int TIMEOUT_CYCLES = 0
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_abort,
  output logic       out_parity_err
);

  localparam int TCNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST =
    (TIMEOUT_CYCLES > 0) ? TCNT_W'(TIMEOUT_CYCLES - 1) : {TCNT_W{1'b0}};
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_BITS - 1);

  state_t            state_r;
  logic [SLOT_W-1:0] slot_r;
  logic [7:0]        acc_r;
  logic [7:0]        out_data_r;
  logic              out_valid_r;
  logic              abort_r;
  logic [TCNT_W-1:0] tcnt_r;

  logic [SLOT_W-1:0] sel_s;
  logic [7:0]        demux_s;
  logic [7:0]        acc_next_s;
  logic              completing_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              acc_wr_s;
  logic              complete_s;
  logic              consume_s;
  logic              mid_frame_s;
  logic              timeout_s;

  // Map slot number to the accumulate bit it fills.
  always_comb begin
    if (MSB_FIRST != 0) begin
      sel_s = SLOT_LAST - slot_r;
    end else begin
      sel_s = slot_r;
    end
  end

  // The completing bit is the last data slot, or the parity bit when enabled.
`ifdef SERIAL_DESER8_PARITY_EN
  assign completing_s = (state_r == PARITY);
`else
  assign completing_s = (state_r == COLLECT) && (slot_r == SLOT_LAST);
`endif

  // Only the completing bit can stall, and only while an unconsumed byte waits.
  always_comb begin
    if (completing_s && out_valid_r && !out_ready) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = 1'b1;
    end
  end

  assign accept_s  = in_valid & in_ready_s;
  assign acc_wr_s  = accept_s & (state_r == COLLECT);
  assign consume_s = out_valid_r & out_ready;

`ifdef SERIAL_DESER8_PARITY_EN
  assign complete_s = accept_s & (state_r == PARITY);
`else
  assign complete_s = accept_s & (slot_r == SLOT_LAST);
`endif

  dmux1to8 u_dmux (
    .in  (in_bit & accept_s),
    .sel (sel_s),
    .y   (demux_s)
  );

  // Next accumulate value: only the selected bit takes the demux output.
  always_comb begin
    acc_next_s = acc_r;
    if (acc_wr_s) begin
      acc_next_s[sel_s] = demux_s[sel_s];
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Timeout fires on an idle cycle mid-frame once the count reaches the limit;
  // an accepted bit in the same cycle always wins.
  always_comb begin
    mid_frame_s = (slot_r != {SLOT_W{1'b0}}) || (state_r != COLLECT);
    if ((TIMEOUT_CYCLES > 0) && mid_frame_s && !accept_s && (tcnt_r == TCNT_LAST)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Frame FSM: slot counter and COLLECT/PARITY state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= COLLECT;
      slot_r  <= {SLOT_W{1'b0}};
    end else if (accept_s) begin
      case (state_r)
        COLLECT: begin
          if (slot_r == SLOT_LAST) begin
            slot_r <= {SLOT_W{1'b0}};
`ifdef SERIAL_DESER8_PARITY_EN
            state_r <= PARITY;
`else
            state_r <= COLLECT;
`endif
          end else begin
            slot_r <= slot_r + SLOT_W'(1);
          end
        end
        PARITY: begin
          slot_r  <= {SLOT_W{1'b0}};
          state_r <= COLLECT;
        end
        default: begin
          slot_r  <= {SLOT_W{1'b0}};
          state_r <= COLLECT;
        end
      endcase
    end else if (timeout_s) begin
      slot_r  <= {SLOT_W{1'b0}};
      state_r <= COLLECT;
    end
  end

  // Accumulate register for the frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= 8'h00;
    end else if (acc_wr_s) begin
      acc_r <= acc_next_s;
    end
  end

  // Output byte register: load on completion, hold until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= 8'h00;
      out_valid_r <= 1'b0;
    end else if (complete_s) begin
`ifdef SERIAL_DESER8_PARITY_EN
      out_data_r <= acc_r;
`else
      out_data_r <= acc_next_s;
`endif
      out_valid_r <= 1'b1;
    end else if (consume_s) begin
      out_valid_r <= 1'b0;
    end
  end

`ifdef SERIAL_DESER8_PARITY_EN
  logic parity_err_r;

  // Parity flag travels with the byte it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_r <= 1'b0;
    end else if (complete_s) begin
      parity_err_r <= even_parity_err(acc_r, in_bit);
    end
  end

  assign out_parity_err = parity_err_r;
`else
  assign out_parity_err = 1'b0;
`endif

  // Idle-cycle counter: runs only mid-frame, cleared by any accepted bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_r <= {TCNT_W{1'b0}};
    end else if ((TIMEOUT_CYCLES == 0) || accept_s || !mid_frame_s || timeout_s) begin
      tcnt_r <= {TCNT_W{1'b0}};
    end else begin
      tcnt_r <= tcnt_r + TCNT_W'(1);
    end
  end

  // One-cycle abort pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_r <= 1'b0;
    end else begin
      abort_r <= timeout_s;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_data    = out_data_r;
  assign out_valid   = out_valid_r;
  assign frame_abort = abort_r;

endmodule

// File: tb/tb_serial_deser8.sv
// tb_serial_deser8
//   Directed bench for serial_deser8. Three instances share the stimulus:
//   d0 LSB-first no timeout, d1 MSB-first no timeout, d2 LSB-first timeout=4.
//   Honors SERIAL_DESER8_PARITY_EN (parity bit appended to each frame).
module tb_serial_deser8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_bit = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;

  logic       d0_in_ready, d0_out_valid, d0_abort, d0_perr;
  logic [7:0] d0_out_data;
  logic       d1_in_ready, d1_out_valid, d1_abort, d1_perr;
  logic [7:0] d1_out_data;
  logic       d2_in_ready, d2_out_valid, d2_abort, d2_perr;
  logic [7:0] d2_out_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_deser8 #(.MSB_FIRST(0), .TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(d0_in_ready), .out_data(d0_out_data), .out_valid(d0_out_valid),
    .out_ready(out_ready), .frame_abort(d0_abort), .out_parity_err(d0_perr));

  serial_deser8 #(.MSB_FIRST(1), .TIMEOUT_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(d1_in_ready), .out_data(d1_out_data), .out_valid(d1_out_valid),
    .out_ready(out_ready), .frame_abort(d1_abort), .out_parity_err(d1_perr));

  serial_deser8 #(.MSB_FIRST(0), .TIMEOUT_CYCLES(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(d2_in_ready), .out_data(d2_out_data), .out_valid(d2_out_valid),
    .out_ready(out_ready), .frame_abort(d2_abort), .out_parity_err(d2_perr));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bit and hold it until accepted (bounded).
  task automatic send_bit(input logic b);
    int n;
    in_valid = 1'b1;
    in_bit   = b;
    n = 0;
    while (!(d0_in_ready && d1_in_ready && d2_in_ready) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_bit_timeout observed=stalled expected=accepted");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_bit(v[i]);
  endtask

  // Parity bit, only in parity builds.
  task automatic finish_frame(input logic [7:0] v);
`ifdef SERIAL_DESER8_PARITY_EN
    send_bit(^v);
`else
    if (v == 8'h00) begin end
`endif
  endtask

  task automatic send_frame(input logic [7:0] v);
    send_bits(v, 0, 7);
    finish_frame(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_out_valid", {7'd0, d0_out_valid}, 8'h00);
    check("rst_out_data", d0_out_data, 8'h00);
    check("rst_abort", {7'd0, d2_abort}, 8'h00);
    check("rst_perr", {7'd0, d0_perr}, 8'h00);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", {7'd0, d0_in_ready}, 8'h01);

    // Reset mid-frame with a pending byte
    out_ready = 1'b0;
    send_frame(8'hC3);
    check("pre_rst_valid", {7'd0, d0_out_valid}, 8'h01);
    check("pre_rst_data", d0_out_data, 8'hC3);
    send_bits(8'hFF, 0, 2);
    rst_n = 1'b0;
    #2;
    check("midrst_out_valid", {7'd0, d0_out_valid}, 8'h00);
    check("midrst_out_data", d0_out_data, 8'h00);
    tick();
    rst_n = 1'b1;

    // LSB-first / MSB-first byte: bits 1,0,1,1,0,0,1,0
    out_ready = 1'b1;
    send_frame(8'h4D);
    check("lsb_valid", {7'd0, d0_out_valid}, 8'h01);
    check("lsb_data", d0_out_data, 8'h4D);
    check("msb_valid", {7'd0, d1_out_valid}, 8'h01);
    check("msb_data", d1_out_data, 8'hB2);
    check("lsb_perr", {7'd0, d0_perr}, 8'h00);
    tick();
    check("lsb_valid_drop", {7'd0, d0_out_valid}, 8'h00);
    check("msb_valid_drop", {7'd0, d1_out_valid}, 8'h00);

    // Backpressure: A5 held, completing bit of 3C stalls
    out_ready = 1'b0;
    send_frame(8'hA5);
    check("bp_a5_valid", {7'd0, d0_out_valid}, 8'h01);
    check("bp_a5_data", d0_out_data, 8'hA5);
`ifdef SERIAL_DESER8_PARITY_EN
    send_bits(8'h3C, 0, 7);
    in_bit = ^(8'h3C);
`else
    send_bits(8'h3C, 0, 6);
    in_bit = 1'b0;
`endif
    in_valid = 1'b1;
    #1;
    check("bp_in_ready_low", {7'd0, d0_in_ready}, 8'h00);
    tick();
    check("bp_in_ready_hold", {7'd0, d0_in_ready}, 8'h00);
    check("bp_hold_data", d0_out_data, 8'hA5);
    check("bp_hold_valid", {7'd0, d0_out_valid}, 8'h01);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_rel", {7'd0, d0_in_ready}, 8'h01);
    check("bp_deliver_a5", d0_out_data, 8'hA5);
    tick();
    in_valid = 1'b0;
    check("bp_3c_valid", {7'd0, d0_out_valid}, 8'h01);
    check("bp_3c_data", d0_out_data, 8'h3C);
    check("bp_3c_msb_data", d1_out_data, 8'h3C);
    tick();
    check("bp_drain", {7'd0, d0_out_valid}, 8'h00);

    // Timeout: idle at slot 0 never aborts
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("to_idle_no_abort", {7'd0, d2_abort}, 8'h00);
    end
    // 3 bits then 4 idle cycles
    send_bits(8'hFF, 0, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_wait_no_abort", {7'd0, d2_abort}, 8'h00);
    end
    tick();
    check("to_abort_pulse", {7'd0, d2_abort}, 8'h01);
    check("to_abort_valid_kept", {7'd0, d2_out_valid}, 8'h00);
    check("to_no_timeout_inst", {7'd0, d0_abort}, 8'h00);
    tick();
    check("to_abort_single", {7'd0, d2_abort}, 8'h00);
    send_frame(8'hFF);
    check("to_ff_valid", {7'd0, d2_out_valid}, 8'h01);
    check("to_ff_data", d2_out_data, 8'hFF);
    tick();

    // Bit arriving on the would-be timeout cycle is accepted, no abort
    do_reset();
    send_bits(8'h5A, 0, 2);
    tick();
    tick();
    tick();
    send_bit(1'b1);
    check("to_coincide_no_abort", {7'd0, d2_abort}, 8'h00);
    send_bits(8'h5A, 4, 7);
    finish_frame(8'h5A);
    check("to_coincide_data", d2_out_data, 8'h5A);
    check("to_coincide_valid", {7'd0, d2_out_valid}, 8'h01);
    tick();

`ifdef SERIAL_DESER8_PARITY_EN
    // Parity: 07 has three ones, even parity bit is 1
    do_reset();
    send_bits(8'h07, 0, 7);
    send_bit(1'b1);
    check("par_ok_data", d0_out_data, 8'h07);
    check("par_ok_err", {7'd0, d0_perr}, 8'h00);
    tick();
    send_bits(8'h07, 0, 7);
    send_bit(1'b0);
    check("par_bad_err", {7'd0, d0_perr}, 8'h01);
    tick();
`else
    check("noparity_err_tied", {7'd0, d2_perr}, 8'h00);
    check("noparity_err_tied_msb", {7'd0, d1_perr}, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
